// File: rtl/mux_rr_sel_gen.sv
// Round-robin select generator for a downstream 4:1 mux: grants one of four
// requesters for a bounded dwell and drives registered Sel/Grant/Valid.
module mux_rr_sel_gen #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Req,
   input  logic       Done,
   output logic [1:0] Sel,
   output logic [3:0] Grant,
   output logic       Valid
);

   localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] last_reg, last_next;
   logic [1:0] sel_reg, sel_next;
   logic [7:0] cnt_reg, cnt_next;
   logic [3:0] grant_reg, grant_next;
   logic       valid_reg, valid_next;

   logic [1:0] cand_idx [4];
   logic [3:0] cand_hit;
   logic [1:0] pick;
   logic       any_req;
   logic       release_now;

   // Candidate k is Last+1+k mod 4; candidate 3 wraps back onto Last itself.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi] = last_reg + 2'(gi + 1);
         assign cand_hit[gi] = Req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      pick = last_reg;
      for (int k = 3; k >= 0; k--) begin
         if (cand_hit[k]) begin
            pick = cand_idx[k];
         end
      end
   end

   assign any_req     = |Req;
   assign release_now = Done || !Req[sel_reg] || (cnt_reg == CNT_LAST);

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      grant_next = grant_reg;
      valid_next = valid_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next = GRANT;
               sel_next   = pick;
               last_next  = pick;
               grant_next = 4'b0001 << pick;
               valid_next = 1'b1;
               cnt_next   = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               if (any_req) begin
                  // Handoff on the same edge: no idle bubble between owners.
                  sel_next   = pick;
                  last_next  = pick;
                  grant_next = 4'b0001 << pick;
                  cnt_next   = 8'd0;
               end else begin
                  // Sel keeps its value so the mux output stays stable.
                  state_next = IDLE;
                  grant_next = 4'b0000;
                  valid_next = 1'b0;
                  cnt_next   = 8'd0;
               end
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = 4'b0000;
            valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         last_reg  <= 2'b11;
         sel_reg   <= 2'b00;
         cnt_reg   <= 8'd0;
         grant_reg <= 4'b0000;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
         grant_reg <= grant_next;
         valid_reg <= valid_next;
      end
   end

   assign Sel   = sel_reg;
   assign Grant = grant_reg;
   assign Valid = valid_reg;

endmodule

// File: tb/tb_mux_rr_sel_gen.sv
// Directed bench for mux_rr_sel_gen: one HOLD_CYCLES=4 instance and one
// HOLD_CYCLES=1 instance sharing clock and reset.
module tb_mux_rr_sel_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req4 = 4'b0000;
   logic       done4 = 1'b0;
   logic [1:0] sel4;
   logic [3:0] grant4;
   logic       valid4;
   logic [3:0] req1 = 4'b0000;
   logic       done1 = 1'b0;
   logic [1:0] sel1;
   logic [3:0] grant1;
   logic       valid1;

   int errors = 0;
   int checks = 0;

   logic [6:0] exp;
   logic [6:0] obs;
   logic [1:0] idx;

   always #5 clk = ~clk;

   mux_rr_sel_gen #(.HOLD_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .Req(req4), .Done(done4),
      .Sel(sel4), .Grant(grant4), .Valid(valid4)
   );

   mux_rr_sel_gen #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .Req(req1), .Done(done1),
      .Sel(sel1), .Grant(grant1), .Valid(valid1)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req4 = 4'b0000; done4 = 1'b0;
      req1 = 4'b0000; done1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      obs = {valid4, grant4, sel4};
      if (obs !== 7'b0_0000_00) begin
         errors++;
         $display("FAIL reset_state: got %b required %b", obs, 7'b0_0000_00);
      end else $display("ok reset_state {V,G,S}=%b", obs);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         obs = {valid4, grant4, sel4};
         if (obs !== 7'b0_0000_00) begin
            errors++;
            $display("FAIL idle_no_req[%0d]: got %b required %b", i, obs, 7'b0_0000_00);
         end else $display("ok idle_no_req[%0d] {V,G,S}=%b", i, obs);
      end
      // Async reset mid-grant, no clock edge in between
      req4 = 4'b0100;
      step();
      checks++;
      obs = {valid4, grant4, sel4};
      if (obs !== 7'b1_0100_10) begin
         errors++;
         $display("FAIL pre_async_grant: got %b required %b", obs, 7'b1_0100_10);
      end else $display("ok pre_async_grant {V,G,S}=%b", obs);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      obs = {valid4, grant4, sel4};
      if (obs !== 7'b0_0000_00) begin
         errors++;
         $display("FAIL async_reset: got %b required %b", obs, 7'b0_0000_00);
      end else $display("ok async_reset {V,G,S}=%b", obs);
      do_reset();
   endtask

   task automatic test_single_req;
      do_reset();
      req4 = 4'b0100;
      for (int i = 0; i < 9; i++) begin
         step();
         checks++;
         obs = {valid4, grant4, sel4};
         if (obs !== 7'b1_0100_10) begin
            errors++;
            $display("FAIL single_req[%0d]: got %b required %b", i, obs, 7'b1_0100_10);
         end else $display("ok single_req[%0d] {V,G,S}=%b", i, obs);
      end
   endtask

   task automatic test_all_req;
      do_reset();
      req4 = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         step();
         idx = 2'((i / 4) % 4);
         exp = {1'b1, 4'b0001 << idx, idx};
         checks++;
         obs = {valid4, grant4, sel4};
         if (obs !== exp) begin
            errors++;
            $display("FAIL all_req[%0d]: got %b required %b", i, obs, exp);
         end else $display("ok all_req[%0d] {V,G,S}=%b", i, obs);
      end
   endtask

   task automatic test_done_release;
      logic [1:0] seq [6];
      seq = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
      do_reset();
      req4 = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         done4 = (i == 1);
         step();
         idx = seq[i];
         exp = {1'b1, 4'b0001 << idx, idx};
         checks++;
         obs = {valid4, grant4, sel4};
         if (obs !== exp) begin
            errors++;
            $display("FAIL done_release[%0d]: got %b required %b", i, obs, exp);
         end else $display("ok done_release[%0d] {V,G,S}=%b", i, obs);
      end
      done4 = 1'b0;
   endtask

   task automatic test_idle_hold;
      logic [3:0] rq [9];
      logic       dn [9];
      logic [6:0] ex [9];
      rq = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      dn = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ex = '{7'b1_0001_00, 7'b0_0000_00, 7'b0_0000_00, 7'b0_0000_00,
             7'b1_0100_10, 7'b0_0000_10, 7'b0_0000_10, 7'b0_0000_10, 7'b1_0001_00};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req4 = rq[i];
         done4 = dn[i];
         step();
         checks++;
         obs = {valid4, grant4, sel4};
         if (obs !== ex[i]) begin
            errors++;
            $display("FAIL idle_hold[%0d]: got %b required %b", i, obs, ex[i]);
         end else $display("ok idle_hold[%0d] {V,G,S}=%b", i, obs);
      end
      req4 = 4'b0000;
      done4 = 1'b0;
   endtask

   task automatic test_back_to_back;
      do_reset();
      req1 = 4'b0110;
      for (int i = 0; i < 8; i++) begin
         // Done coincides with hold expiry on cycles 6 and 7: still one advance each
         done1 = (i >= 6);
         step();
         idx = (i % 2 == 0) ? 2'd1 : 2'd2;
         exp = {1'b1, 4'b0001 << idx, idx};
         checks++;
         obs = {valid1, grant1, sel1};
         if (obs !== exp) begin
            errors++;
            $display("FAIL hold1_rotate[%0d]: got %b required %b", i, obs, exp);
         end else $display("ok hold1_rotate[%0d] {V,G,S}=%b", i, obs);
      end
      done1 = 1'b0;
      req1 = 4'b0000;
      step();
      checks++;
      obs = {valid1, grant1, sel1};
      if (obs !== 7'b0_0000_10) begin
         errors++;
         $display("FAIL hold1_idle: got %b required %b", obs, 7'b0_0000_10);
      end else $display("ok hold1_idle {V,G,S}=%b", obs);
   endtask

   initial begin
      test_reset();
      test_single_req();
      test_all_req();
      test_done_release();
      test_idle_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
